reg_pipe_nbit: RTL and testbench
================================

// Module: reg_pipe_nbit
// PURPOSE
//   Parametrised DEPTH-stage, WIDTH-bit pipeline register with per-stage valid bits,
//   global stall and synchronous flush. Carries operands/results through the multi-cycle
//   MultDiv datapath and reports pipeline occupancy to the control FSM.
//   Generalises the single N-bit enabled register into a stallable, flushable shift pipeline.
// PARAMETERS
//   WIDTH      32   data bits per stage (>=1)
//   DEPTH      4    number of stages (>=1); latency in cycles when not stalled
//   RESET_VAL  0    WIDTH-bit value loaded into every data stage on reset
//   FLUSH_DATA 0    1: flush also loads RESET_VAL into data stages; 0: flush clears valids only
// PORTS
//   clock      in   1                      rising-edge clock
//   resetn     in   1                      asynchronous reset, active-high (1 = clear)
//   in_data    in   WIDTH                  data entering stage 0
//   in_valid   in   1                      in_data is valid this cycle
//   stall      in   1                      1 = hold every stage (data and valid)
//   flush      in   1                      1 = invalidate every stage at next edge
//   out_data   out  WIDTH                  data of stage DEPTH-1
//   out_valid  out  1                      valid bit of stage DEPTH-1
//   busy       out  1                      OR of all stage valid bits
//   occupancy  out  $clog2(DEPTH+1)        count of valid stages, 0..DEPTH
// BEHAVIOUR
//   - Reset (resetn=1, async, overrides clock): data stages = RESET_VAL, valids = 0,
//     occupancy = 0, busy = 0, out_valid = 0. Reset mid-operation discards all contents.
//   - Priority per rising edge: flush > stall > advance.
//   - Advance (stall=0, flush=0): stage[0] <= {in_valid, in_data}; stage[i] <= stage[i-1].
//     Data in stage 0 is captured regardless of in_valid; only valid qualifies it.
//     An item accepted at edge k appears on out_data/out_valid after edge k+DEPTH-1
//     (visible DEPTH cycles after being presented).
//   - Stall (stall=1, flush=0): all data and valid bits hold; in_data/in_valid ignored
//     (upstream holds its item). out_* remain stable.
//   - Flush (flush=1, any stall): all valids <= 0; in_valid that cycle is dropped.
//     Data stages hold (FLUSH_DATA=0) or load RESET_VAL (FLUSH_DATA=1).
//   - Outputs are registered stage state (no combinational path from inputs to outputs).
//   - occupancy: registered; tracks valid bits exactly; updated from next-state valids
//     (+1 if in_valid enters, -1 if last-stage valid leaves, 0 on flush). Never exceeds DEPTH.
//   - busy = (occupancy != 0); out_valid falls the cycle after the last valid item shifts out.
//   - DEPTH=1: single register; same rules, latency 1.
//   - Bubbles (in_valid=0) advance like items; no bubble collapsing.
// TESTING
//   1. WIDTH=32,DEPTH=4: in_valid=1, in_data=0xA5A5_0001 one cycle -> out_valid=1 with
//      0xA5A5_0001 exactly 4 edges later, for one cycle; occupancy 1,1,1,1,0.
//   2. Stream 0x1..0x6 back-to-back -> outputs 0x1..0x6 in order, no gaps; occupancy peaks at 4.
//   3. Stream 0x10,0x11; stall=1 for 3 cycles mid-flight -> outputs held stable, total
//      latency 4+3 cycles, no duplicates, no loss.
//   4. Pipe full (4 items), flush=1 together with stall=1 and in_valid=1 -> next cycle
//      out_valid=0, occupancy=0, busy=0; FLUSH_DATA=1 build shows out_data=RESET_VAL.
//   5. Assert resetn asynchronously between edges with 3 items inside -> all outputs cleared
//      immediately (before next edge), out_data=RESET_VAL; resume streaming works after release.
//   6. DEPTH=1, RESET_VAL=0xFFFF_FFFF: reset -> out_data=0xFFFF_FFFF; in 0x7 -> out next edge.

Source files
------------

// File: rtl/reg_pipe_nbit.sv
// reg_pipe_nbit: DEPTH-stage, WIDTH-bit shift pipeline with per-stage valid
// bits, global stall and synchronous flush. It carries operands and results
// through the multi-cycle MultDiv datapath and reports how many stages hold
// live items. All outputs come straight from registers.
module reg_pipe_nbit #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter bit               FLUSH_DATA = 1'b0
) (
  input  logic                           clock,
  input  logic                           resetn,     // active-high despite the name
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_valid,
  input  logic                           stall,
  input  logic                           flush,
  output logic [WIDTH-1:0]               out_data,
  output logic                           out_valid,
  output logic                           busy,
  output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] dataQ [DEPTH];
  logic [DEPTH-1:0] validQ;
  logic [OCC_W-1:0] occQ;
  logic [OCC_W-1:0] occNext;

  // Data stages: shift on advance, hold on stall, optionally reload on flush.
  // NOTE: every stage is reset because RESET_VAL is visible on out_data; a
  // storage array that software never observes before writing would not need it.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < DEPTH; i++) dataQ[i] <= RESET_VAL;
    end else if (flush) begin
      if (FLUSH_DATA) begin
        for (int i = 0; i < DEPTH; i++) dataQ[i] <= RESET_VAL;
      end
    end else if (!stall) begin
      // NOTE: non-blocking assignments make every stage read the pre-edge
      // value of its predecessor, so the loop order does not matter.
      dataQ[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) dataQ[i] <= dataQ[i-1];
    end
  end

  // Valid bits: cleared by flush, held by stall, shifted alongside data.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      validQ <= '0;
    end else if (flush) begin
      validQ <= '0;
    end else if (!stall) begin
      validQ[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) validQ[i] <= validQ[i-1];
    end
  end

  // Next occupancy: +1 for an entering item, -1 for the item leaving the last stage.
  always_comb begin
    // NOTE: default first so no path through this block leaves occNext
    // unassigned, which would otherwise infer a latch.
    occNext = occQ;
    if (flush) begin
      occNext = '0;
    end else if (!stall) begin
      occNext = occQ + OCC_W'(in_valid) - OCC_W'(validQ[DEPTH-1]);
    end
  end

  // Registered occupancy count, always equal to the number of set valid bits.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) occQ <= '0;
    else        occQ <= occNext;
  end

  assign out_data  = dataQ[DEPTH-1];
  assign out_valid = validQ[DEPTH-1];
  assign occupancy = occQ;
  assign busy      = (occQ != '0);

endmodule

// File: tb/tb_reg_pipe_nbit.sv
// tb_reg_pipe_nbit: directed test of reg_pipe_nbit. Instance A is the default
// build (FLUSH_DATA=0), instance B shares A's inputs but reloads data on flush,
// instance C is the DEPTH=1 build with an all-ones reset value.
module tb_reg_pipe_nbit;

  localparam logic [31:0] RV_B = 32'h0BAD_0000;
  localparam logic [31:0] RV_C = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] inData;
  logic        inValid, stall, flush;
  logic [31:0] cData;
  logic        cValid;
  logic        cStall, cFlush;

  logic [31:0] aData, bData, cOut;
  logic        aValid, bValid, cOutValid;
  logic        aBusy, bBusy, cBusy;
  logic [2:0]  aOcc, bOcc;
  logic [0:0]  cOcc;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clock = ~clock;

  reg_pipe_nbit #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'h0), .FLUSH_DATA(1'b0)) dutA (
    .clock(clock), .resetn(rst), .in_data(inData), .in_valid(inValid),
    .stall(stall), .flush(flush), .out_data(aData), .out_valid(aValid),
    .busy(aBusy), .occupancy(aOcc));

  reg_pipe_nbit #(.WIDTH(32), .DEPTH(4), .RESET_VAL(RV_B), .FLUSH_DATA(1'b1)) dutB (
    .clock(clock), .resetn(rst), .in_data(inData), .in_valid(inValid),
    .stall(stall), .flush(flush), .out_data(bData), .out_valid(bValid),
    .busy(bBusy), .occupancy(bOcc));

  reg_pipe_nbit #(.WIDTH(32), .DEPTH(1), .RESET_VAL(RV_C), .FLUSH_DATA(1'b0)) dutC (
    .clock(clock), .resetn(rst), .in_data(cData), .in_valid(cValid),
    .stall(cStall), .flush(cFlush), .out_data(cOut), .out_valid(cOutValid),
    .busy(cBusy), .occupancy(cOcc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic v, input logic s, input logic f);
    inData = d; inValid = v; stall = s; flush = f;
  endtask

  task automatic checkA(input string tag, input logic v, input logic [2:0] occ);
    check({tag, ".valid"}, {31'b0, aValid}, {31'b0, v});
    check({tag, ".occ"},   {29'b0, aOcc},   {29'b0, occ});
    check({tag, ".busy"},  {31'b0, aBusy},  {31'b0, (occ != 3'd0)});
  endtask

  initial begin
    int expOcc;
    int peak;

    rst = 1'b1;
    drive(32'h0, 1'b0, 1'b0, 1'b0);
    cData = 32'h0; cValid = 1'b0; cStall = 1'b0; cFlush = 1'b0;
    #2;
    // ---------------- reset state ----------------
    checkA("rst", 1'b0, 3'd0);
    check("rst.data", aData, 32'h0);
    check("rst.B.data", bData, RV_B);
    check("rst.C.data", cOut, RV_C);
    check("rst.C.valid", {31'b0, cOutValid}, 32'h0);
    #10 rst = 1'b0;                      // released between edges (t=12)

    // ---------------- test 1: single item, latency 4 ----------------
    drive(32'hA5A5_0001, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 5; e++) begin
      tick();
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      checkA($sformatf("t1.e%0d", e), (e == 4), (e <= 4) ? 3'd1 : 3'd0);
      if (e == 4) check("t1.data", aData, 32'hA5A5_0001);
    end

    // ---------------- test 2: back-to-back stream 1..6 ----------------
    peak = 0;
    for (int j = 1; j <= 10; j++) begin
      if (j <= 6) drive(j, 1'b1, 1'b0, 1'b0);
      else        drive(32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      expOcc = 0;
      for (int i = 1; i <= 6; i++) if (i <= j && j <= i + 3) expOcc++;
      if (int'(aOcc) > peak) peak = int'(aOcc);
      checkA($sformatf("t2.e%0d", j), (j >= 4 && j <= 9), 3'(expOcc));
      if (j >= 4 && j <= 9) check($sformatf("t2.data%0d", j), aData, j - 3);
    end
    check("t2.peak", peak, 32'd4);

    // ---------------- test 3: stall 3 cycles mid-flight ----------------
    for (int j = 1; j <= 9; j++) begin
      if (j == 1)                drive(32'h10, 1'b1, 1'b0, 1'b0);
      else if (j == 2)           drive(32'h11, 1'b1, 1'b0, 1'b0);
      else if (j >= 3 && j <= 5) drive(32'hBAD, 1'b1, 1'b1, 1'b0);  // ignored while stalled
      else                       drive(32'h0, 1'b0, 1'b0, 1'b0);
      tick();
      case (j)
        1:       expOcc = 1;
        8:       expOcc = 1;
        9:       expOcc = 0;
        default: expOcc = 2;
      endcase
      checkA($sformatf("t3.e%0d", j), (j == 7 || j == 8), 3'(expOcc));
      if (j == 7) check("t3.data0", aData, 32'h10);
      if (j == 8) check("t3.data1", aData, 32'h11);
    end

    // ---------------- test 4: flush on a full pipe ----------------
    for (int j = 1; j <= 4; j++) begin
      drive(32'h20 + j, 1'b1, 1'b0, 1'b0);
      tick();
    end
    checkA("t4.full", 1'b1, 3'd4);
    check("t4.fullData", aData, 32'h21);
    drive(32'h99, 1'b1, 1'b1, 1'b1);
    tick();
    checkA("t4.flush", 1'b0, 3'd0);
    check("t4.holdData", aData, 32'h21);
    check("t4.B.valid", {31'b0, bValid}, 32'h0);
    check("t4.B.occ", {29'b0, bOcc}, 32'h0);
    check("t4.B.busy", {31'b0, bBusy}, 32'h0);
    check("t4.B.data", bData, RV_B);
    // The item offered during the flush must never emerge.
    for (int j = 1; j <= 4; j++) begin
      drive(32'h77, 1'b0, 1'b0, 1'b0);
      tick();
      checkA($sformatf("t4.after%0d", j), 1'b0, 3'd0);
    end

    // ---------------- test 5: async reset mid-operation ----------------
    for (int j = 1; j <= 3; j++) begin
      drive(32'h30 + j, 1'b1, 1'b0, 1'b0);
      tick();
    end
    checkA("t5.pre", 1'b0, 3'd3);
    check("t5.preData", aData, 32'h77);
    #2 rst = 1'b1;                       // between edges
    #1;
    checkA("t5.rst", 1'b0, 3'd0);
    check("t5.rstData", aData, 32'h0);
    check("t6.rstC", cOut, RV_C);
    #2 rst = 1'b0;
    drive(32'h41, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 4; e++) begin
      tick();
      drive(32'h0, 1'b0, 1'b0, 1'b0);
    end
    checkA("t5.resume", 1'b1, 3'd1);
    check("t5.resumeData", aData, 32'h41);

    // ---------------- test 6: DEPTH=1 ----------------
    cData = 32'h7; cValid = 1'b1;
    tick();
    cData = 32'h0; cValid = 1'b0;
    check("t6.valid", {31'b0, cOutValid}, 32'h1);
    check("t6.data", cOut, 32'h7);
    check("t6.occ", {31'b0, cOcc}, 32'h1);
    check("t6.busy", {31'b0, cBusy}, 32'h1);
    tick();
    check("t6.drain", {31'b0, cOutValid}, 32'h0);
    check("t6.occ0", {31'b0, cOcc}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
